// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-segment scan decoder: glyph table,
// blank pattern, FSM state encoding and the decoded-glyph bundle.
package seg_scan_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef struct packed {
        logic       known;
        logic       blank;
        logic [3:0] nibble;
    } glyph_t;

endpackage

// File: rtl/seg_scan_decoder_glyph.sv
// seg_glyph_decode: active-low gfedcba pattern to {known, blank, nibble}.
// Purely combinational; reusable by display encoder checks.
module seg_glyph_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg_i,
    output glyph_t     glyph_o
);

    logic [4:0] kn;

    always_comb begin
        kn = 5'b0_0000;
        case (seg_i)
            GLYPH_0: kn = {1'b1, 4'h0};
            GLYPH_1: kn = {1'b1, 4'h1};
            GLYPH_2: kn = {1'b1, 4'h2};
            GLYPH_3: kn = {1'b1, 4'h3};
            GLYPH_4: kn = {1'b1, 4'h4};
            GLYPH_5: kn = {1'b1, 4'h5};
            GLYPH_6: kn = {1'b1, 4'h6};
            GLYPH_7: kn = {1'b1, 4'h7};
            GLYPH_8: kn = {1'b1, 4'h8};
            GLYPH_9: kn = {1'b1, 4'h9};
            GLYPH_A: kn = {1'b1, 4'hA};
            GLYPH_B: kn = {1'b1, 4'hB};
            GLYPH_C: kn = {1'b1, 4'hC};
            GLYPH_D: kn = {1'b1, 4'hD};
            GLYPH_E: kn = {1'b1, 4'hE};
            GLYPH_F: kn = {1'b1, 4'hF};
            default: kn = 5'b0_0000;
        endcase
    end

    assign glyph_o.known  = kn[4];
    assign glyph_o.nibble = kn[3:0];
    assign glyph_o.blank  = (seg_i == SEG_BLANK);

endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment scan monitor: rebuilds per-digit hex values.
// Optional decimal-point capture is enabled with SEG_SCAN_DP_EN.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS      = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            SEG,
    input  logic [7:0]            AN,
    input  logic                  clr,
    output logic [4*N_DIGITS-1:0] value,
    output logic [N_DIGITS-1:0]   digit_valid,
    output logic [N_DIGITS-1:0]   digit_blank,
    output logic                  frame_done,
    output logic                  err_an,
    output logic                  err_seg
`ifdef SEG_SCAN_DP_EN
    ,
    output logic [N_DIGITS-1:0]   dp
`endif
);

`ifdef SEG_SCAN_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
    logic unused_seg7;
    assign unused_seg7 = SEG[7];
`endif

    localparam logic [7:0] DIG_MASK =
        8'((9'd1 << N_DIGITS) - 9'd1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(STABLE_CYCLES - 1);
    localparam logic [N_DIGITS-1:0] ALL_DIG = '1;

    logic [SW-1:0] s_seg_q, p_seg_q;
    logic [7:0]    s_an_q, p_an_q;

    // Idle-high reset keeps a fresh start from looking like a bad AN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg_q <= '1;
            p_seg_q <= '1;
            s_an_q  <= '1;
            p_an_q  <= '1;
        end else begin
            s_seg_q <= SEG[SW-1:0];
            p_seg_q <= s_seg_q;
            s_an_q  <= AN;
            p_an_q  <= s_an_q;
        end
    end

    logic [7:0] an_low;
    logic       an_idle, an_legal, an_bad, change;

    assign an_low   = ~s_an_q;
    assign an_idle  = (s_an_q == 8'hFF);
    assign an_legal = (an_low != 8'd0)
                   && ((an_low & (an_low - 8'd1)) == 8'd0)
                   && ((an_low & ~DIG_MASK) == 8'd0);
    assign an_bad   = !an_idle && !an_legal;
    assign change   = (s_seg_q != p_seg_q) || (s_an_q != p_an_q);

    glyph_t glyph;

    seg_glyph_decode u_glyph (
        .seg_i   (s_seg_q[6:0]),
        .glyph_o (glyph)
    );

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (an_bad) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (an_legal) begin
                        state_d = ST_TRACK;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_TRACK: begin
                    if (change) begin
                        state_d = an_legal ? ST_TRACK : ST_IDLE;
                        cnt_d   = an_legal ? CNT_W'(1) : '0;
                    end else if (cnt_q == CNT_LAST) begin
                        commit  = 1'b1;
                        state_d = ST_HOLD;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (change) begin
                        state_d = an_legal ? ST_TRACK : ST_IDLE;
                        cnt_d   = an_legal ? CNT_W'(1) : '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    logic [4*N_DIGITS-1:0] value_q, value_d;
    logic [N_DIGITS-1:0]   valid_q, valid_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d;
    logic [N_DIGITS-1:0]   mask_q, mask_d, fmask, sel;
    logic                  done_q, done_d;
    logic                  err_an_q, err_an_d;
    logic                  err_seg_q, err_seg_d;
`ifdef SEG_SCAN_DP_EN
    logic [N_DIGITS-1:0]   dp_q, dp_d;
`endif

    assign sel   = an_low[N_DIGITS-1:0] & {N_DIGITS{commit}};
    assign fmask = mask_q | sel;

    always_comb begin
        value_d   = value_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        mask_d    = mask_q;
        done_d    = 1'b0;
        err_an_d  = err_an_q | an_bad;
        err_seg_d = err_seg_q;
`ifdef SEG_SCAN_DP_EN
        dp_d      = dp_q;
`endif
        for (int i = 0; i < N_DIGITS; i++) begin
            if (sel[i]) begin
                if (glyph.known) begin
                    value_d[4*i +: 4] = glyph.nibble;
                    valid_d[i]        = 1'b1;
                    blank_d[i]        = 1'b0;
                end else if (glyph.blank) begin
                    valid_d[i] = 1'b1;
                    blank_d[i] = 1'b1;
                end else begin
                    valid_d[i] = 1'b0;
                    blank_d[i] = 1'b0;
                    err_seg_d  = 1'b1;
                end
`ifdef SEG_SCAN_DP_EN
                dp_d[i] = ~s_seg_q[7];
`endif
            end
        end
        // Completing commit closes this frame; the next one starts empty.
        if (commit) begin
            if (fmask == ALL_DIG) begin
                done_d = 1'b1;
                mask_d = '0;
            end else begin
                mask_d = fmask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            value_q   <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            mask_q    <= '0;
            done_q    <= 1'b0;
            err_an_q  <= 1'b0;
            err_seg_q <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            dp_q      <= '0;
`endif
        end else if (clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            value_q   <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            mask_q    <= '0;
            done_q    <= 1'b0;
            err_an_q  <= 1'b0;
            err_seg_q <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            dp_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            mask_q    <= mask_d;
            done_q    <= done_d;
            err_an_q  <= err_an_d;
            err_seg_q <= err_seg_d;
`ifdef SEG_SCAN_DP_EN
            dp_q      <= dp_d;
`endif
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign digit_blank = blank_q;
    assign frame_done  = done_q;
    assign err_an      = err_an_q;
    assign err_seg     = err_seg_q;
`ifdef SEG_SCAN_DP_EN
    assign dp          = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (N_DIGITS=2, STABLE_CYCLES=4).
// Build with SEG_SCAN_DP_EN defined to also cover decimal-point capture.
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] SEG = 8'hFF;
    logic [7:0] AN = 8'hFF;
    logic [7:0] value;
    logic [1:0] digit_valid;
    logic [1:0] digit_blank;
    logic       frame_done;
    logic       err_an;
    logic       err_seg;
`ifdef SEG_SCAN_DP_EN
    logic [1:0] dp;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .N_DIGITS      (2),
        .STABLE_CYCLES (4),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SEG         (SEG),
        .AN          (AN),
        .clr         (clr),
        .value       (value),
        .digit_valid (digit_valid),
        .digit_blank (digit_blank),
        .frame_done  (frame_done),
        .err_an      (err_an),
        .err_seg     (err_seg)
`ifdef SEG_SCAN_DP_EN
        ,
        .dp          (dp)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] an, input logic [7:0] seg);
        AN  = an;
        SEG = seg;
    endtask

    initial begin
        // reset state
        wait_n(2);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_blank", 32'(digit_blank), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        chk("rst_err_an", 32'(err_an), 32'h0);
        chk("rst_err_seg", 32'(err_seg), 32'h0);
        rst_n = 1'b1;
        wait_n(2);

        // two-digit frame: '2' on digit 0, '3' on digit 1
        drive(8'hFE, 8'h24);
        wait_n(4);
        chk("f1_d0_early", 32'(digit_valid), 32'h0);
        wait_n(1);
        chk("f1_d0_value", 32'(value), 32'h02);
        chk("f1_d0_valid", 32'(digit_valid), 32'h1);
        chk("f1_d0_nodone", 32'(frame_done), 32'h0);
        wait_n(3);
        drive(8'hFD, 8'h30);
        wait_n(4);
        chk("f1_d1_early", 32'(frame_done), 32'h0);
        wait_n(1);
        chk("f1_value", 32'(value), 32'h32);
        chk("f1_valid", 32'(digit_valid), 32'h3);
        chk("f1_done", 32'(frame_done), 32'h1);
        wait_n(1);
        chk("f1_done_pulse", 32'(frame_done), 32'h0);
        wait_n(2);

        // short '1' glitch, then stable '5'
        drive(8'hFE, 8'h79);
        wait_n(3);
        chk("gl_nocommit", 32'(value), 32'h32);
        drive(8'hFE, 8'h12);
        wait_n(4);
        chk("gl_early", 32'(value), 32'h32);
        wait_n(1);
        chk("gl_value5", 32'(value), 32'h35);
        chk("gl_nodone", 32'(frame_done), 32'h0);
        wait_n(1);

        // two anodes low is illegal; clr wipes it
        drive(8'hFC, 8'h24);
        wait_n(2);
        chk("an_err_set", 32'(err_an), 32'h1);
        wait_n(3);
        chk("an_err_nocommit", 32'(value), 32'h35);
        chk("an_err_valid", 32'(digit_valid), 32'h3);
        AN  = 8'hFF;
        clr = 1'b1;
        wait_n(1);
        clr = 1'b0;
        chk("clr_err_an", 32'(err_an), 32'h0);
        chk("clr_value", 32'(value), 32'h0);
        chk("clr_valid", 32'(digit_valid), 32'h0);
        wait_n(2);
        chk("clr_err_an_hold", 32'(err_an), 32'h0);

        // unknown glyph, then blank
        drive(8'hFE, 8'h55);
        wait_n(4);
        chk("seg_err_early", 32'(err_seg), 32'h0);
        wait_n(1);
        chk("seg_err_set", 32'(err_seg), 32'h1);
        chk("seg_err_valid", 32'(digit_valid), 32'h0);
        wait_n(1);
        drive(8'hFE, 8'h7F);
        wait_n(5);
        chk("blank_valid", 32'(digit_valid), 32'h1);
        chk("blank_flag", 32'(digit_blank), 32'h1);
        chk("blank_value", 32'(value), 32'h0);
        chk("blank_err_sticky", 32'(err_seg), 32'h1);
        wait_n(1);

        // async reset mid-count
        drive(8'hFD, 8'h79);
        wait_n(3);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_err_seg", 32'(err_seg), 32'h0);
        chk("mr_valid", 32'(digit_valid), 32'h0);
        chk("mr_blank", 32'(digit_blank), 32'h0);
        #1 rst_n = 1'b1;
        wait_n(4);
        chk("mr_early", 32'(digit_valid), 32'h0);
        wait_n(1);
        chk("mr_value", 32'(value), 32'h10);
        chk("mr_valid_d1", 32'(digit_valid), 32'h2);
        wait_n(1);

        // '0' with decimal point lit on digit 1
        drive(8'hFD, 8'h40);
        wait_n(5);
        chk("dp_value", 32'(value), 32'h00);
        chk("dp_valid", 32'(digit_valid), 32'h2);
`ifdef SEG_SCAN_DP_EN
        chk("dp_d1", 32'(dp), 32'h2);
`endif
        wait_n(1);

        // SEG[7]-only change mid-count on digit 0
        drive(8'hFE, 8'h06);
        wait_n(2);
        SEG = 8'h86;
        wait_n(3);
`ifdef SEG_SCAN_DP_EN
        chk("dpchg_restart", 32'(value), 32'h00);
        wait_n(2);
        chk("dpchg_dp", 32'(dp), 32'h2);
`endif
        chk("dpchg_value", 32'(value), 32'h0E);
        chk("dpchg_valid", 32'(digit_valid), 32'h3);
        chk("dpchg_done", 32'(frame_done), 32'h1);
        wait_n(1);
        chk("dpchg_done_pulse", 32'(frame_done), 32'h0);

        // anode outside the digit range
        drive(8'hFB, 8'h06);
        wait_n(2);
        chk("an_range_err", 32'(err_an), 32'h1);
        wait_n(4);
        chk("an_range_valid", 32'(digit_valid), 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
